// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and constants for the tiny-ALU command
//               sequencer: FSM state encoding, opcode / flag-select codes,
//               command FIFO entry layout and ALU control-bus bit positions.
// Config      : ALUSEQ_CHAIN_EN adds a chain bit to each command entry.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_RESP   = 3'd4
  } seq_state_e;

  // Opcodes that have defined result semantics on the ALU side
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b111;

  // Flag selects
  localparam logic [1:0] FSEL_A_GT_B = 2'b00;
  localparam logic [1:0] FSEL_A_EQ_B = 2'b01;
  localparam logic [1:0] FSEL_A_ZERO = 2'b10;
  localparam logic [1:0] FSEL_A_EVEN = 2'b11;

  // alu_ctrl (ALU uio_in) layout; bits [7:6] stay zero
  localparam int CTRL_OP_LSB   = 0;
  localparam int CTRL_OP_MSB   = 2;
  localparam int CTRL_ENA_BIT  = 3;
  localparam int CTRL_FSEL_LSB = 4;
  localparam int CTRL_FSEL_MSB = 5;

  // alu_hi (ALU uio_out) layout
  localparam int HI_RES_MSB  = 5;
  localparam int HI_FLAG_BIT = 6;
  localparam int HI_OVF_BIT  = 7;

  typedef struct packed {
`ifdef ALUSEQ_CHAIN_EN
    logic       chain;
`endif
    logic [2:0] op;
    logic [1:0] fsel;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_entry_t;

  localparam int CMD_W = $bits(cmd_entry_t);

  function automatic logic [7:0] ctrl_word(input logic [2:0] op,
                                           input logic [1:0] fsel,
                                           input logic       ena);
    logic [7:0] c;
    c = '0;
    c[CTRL_OP_MSB:CTRL_OP_LSB]     = op;
    c[CTRL_ENA_BIT]                = ena;
    c[CTRL_FSEL_MSB:CTRL_FSEL_LSB] = fsel;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Synchronous FIFO with wrap-around pointers carrying one
//               extra bit, so full/empty come from a pointer compare and the
//               occupancy is a plain pointer difference.
// Ports       : clk, rst_n (async active-low)
//               push_i/din_i  - write request / data (ignored when full)
//               pop_i/dout_o  - read request / head data (ignored when empty)
//               full_o, empty_o, level_o - status from registered pointers
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 21,
  parameter int LEVEL_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   din_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   dout_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [LEVEL_W-1:0] wr_ptr_q, rd_ptr_q;
  logic               push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + LEVEL_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + LEVEL_W'(1);
    end
  end

  // Storage is not reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Buffers ALU commands and sequences each one onto the tiny
//               ALU's shared input bus (load A, load B, execute), then
//               captures the 14-bit result, flag and overflow and offers them
//               on a valid/ready result port.
// Ports       : cmd_*     - command input (valid/ready), chain is optional
//               res_*     - result output (valid/ready)
//               alu_ui    - ALU ui_in;  alu_ctrl - ALU uio_in
//               alu_lo    - ALU uo_out; alu_hi   - ALU uio_out
//               busy      - sequencing or commands pending
//               fifo_level- command FIFO occupancy
// Config      : ALUSEQ_CHAIN_EN - a chained command uses the low byte of the
//               previous result as operand A.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_fsel,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_chain,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [13:0]      res_data,
  output logic             res_flag,
  output logic             res_ovf,
  output logic [7:0]       alu_ui,
  output logic [7:0]       alu_ctrl,
  input  logic [7:0]       alu_lo,
  input  logic [7:0]       alu_hi,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_level
);

  import alu_seq_pkg::*;

  seq_state_e  state_q, state_d;
  cmd_entry_t  cmd_q;
  cmd_entry_t  fifo_din, fifo_dout;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic        run_q;
  logic [13:0] res_data_q;
  logic        res_flag_q, res_ovf_q, res_valid_q;
  logic [7:0]  a_sel;

  // run_q holds cmd_ready low for the whole reset and releases it on the
  // first clock after rst_n deasserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // A pop in the same cycle does not free space: ready uses the registered
  // full state only.
  assign cmd_ready = run_q & ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;

  always_comb begin
    fifo_din      = '0;
    fifo_din.op   = cmd_op;
    fifo_din.fsel = cmd_fsel;
    fifo_din.a    = cmd_a;
    fifo_din.b    = cmd_b;
`ifdef ALUSEQ_CHAIN_EN
    fifo_din.chain = cmd_chain;
`endif
  end

  alu_cmd_fifo #(
    .DEPTH   (CMD_DEPTH),
    .WIDTH   (CMD_W),
    .LEVEL_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_LOAD_A;
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_EXEC;
      S_EXEC:   state_d = S_RESP;
      S_RESP:   if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      res_data_q  <= '0;
      res_flag_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) cmd_q <= fifo_dout;
      if (state_q == S_EXEC) begin
        res_data_q  <= {alu_hi[HI_RES_MSB:0], alu_lo};
        res_flag_q  <= alu_hi[HI_FLAG_BIT];
        res_ovf_q   <= alu_hi[HI_OVF_BIT];
        res_valid_q <= 1'b1;
      end else if ((state_q == S_RESP) && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Operand A source
  // --------------------------------------------------------------------------
`ifdef ALUSEQ_CHAIN_EN
  logic [7:0] last_lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 last_lo_q <= '0;
    else if (state_q == S_EXEC) last_lo_q <= alu_lo;
  end

  assign a_sel = cmd_q.chain ? last_lo_q : cmd_q.a;
`else
  logic chain_unused;
  assign chain_unused = cmd_chain;
  assign a_sel        = cmd_q.a;
`endif

  // --------------------------------------------------------------------------
  // ALU bus decode. The ALU reloads its B register on every cycle with enA=0,
  // so B stays on the bus after LOAD_B to keep the operand stable through
  // EXEC (and RESP).
  // --------------------------------------------------------------------------
  always_comb begin
    alu_ui   = '0;
    alu_ctrl = '0;
    case (state_q)
      S_LOAD_A: begin
        alu_ui   = a_sel;
        alu_ctrl = ctrl_word(cmd_q.op, cmd_q.fsel, 1'b1);
      end
      S_LOAD_B, S_EXEC, S_RESP: begin
        alu_ui   = cmd_q.b;
        alu_ctrl = ctrl_word(cmd_q.op, cmd_q.fsel, 1'b0);
      end
      default: ;
    endcase
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_flag  = res_flag_q;
  assign res_ovf   = res_ovf_q;
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer with a behavioural
//               tiny-ALU attached to its bus and a result scoreboard.
// Config      : ALUSEQ_CHAIN_EN selects chained-operand expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_chain;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_fsel;
  logic [7:0]  cmd_a, cmd_b;
  logic        res_valid, res_ready, res_flag, res_ovf;
  logic [13:0] res_data;
  logic [7:0]  alu_ui, alu_ctrl, alu_lo, alu_hi;
  logic        busy;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  model_last_lo;
  logic [13:0] got_data;
  logic        got_flag, got_ovf;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.CMD_DEPTH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_fsel   (cmd_fsel),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_chain  (cmd_chain),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flag   (res_flag),
    .res_ovf    (res_ovf),
    .alu_ui     (alu_ui),
    .alu_ctrl   (alu_ctrl),
    .alu_lo     (alu_lo),
    .alu_hi     (alu_hi),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  // Arithmetic meaning of an ALU operation: {ovf, flag, result[13:0]}
  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [1:0] fs,
                                        input logic [7:0] a, input logic [7:0] b);
    int          s;
    logic        fl;
    logic [13:0] r;
    case (op)
      OP_ADD:  s = int'(a) + int'(b);
      OP_SUB:  s = int'(a) - int'(b);
      OP_MULT: s = int'(a) * int'(b);
      default: s = 0;
    endcase
    case (fs)
      FSEL_A_GT_B: fl = (a > b);
      FSEL_A_EQ_B: fl = (a == b);
      FSEL_A_ZERO: fl = (a == 8'd0);
      default:     fl = ~a[0];
    endcase
    r = 14'(s);
    return {((s < 0) || (s > 255)), fl, r};
  endfunction

  // Tiny ALU: A loads when enA=1, otherwise B loads; outputs follow registers.
  logic [7:0]  alu_a_r, alu_b_r;
  logic [15:0] alu_w;
  always @(posedge clk) begin
    if (alu_ctrl[CTRL_ENA_BIT]) alu_a_r <= alu_ui;
    else                        alu_b_r <= alu_ui;
  end
  always_comb begin
    alu_w  = alu_f(alu_ctrl[2:0], alu_ctrl[5:4], alu_a_r, alu_b_r);
    alu_lo = alu_w[7:0];
    alu_hi = alu_w[15:8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] fs,
                      input logic [7:0] a, input logic [7:0] b, input logic ch);
    logic [7:0]  a_eff;
    logic [15:0] e;
    int          k;
    cmd_op = op; cmd_fsel = fs; cmd_a = a; cmd_b = b; cmd_chain = ch;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 40) begin
      tick();
      k++;
    end
    if (!cmd_ready) begin
      check("send_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    a_eff = a;
`ifdef ALUSEQ_CHAIN_EN
    if (ch) a_eff = model_last_lo;
`endif
    e = alu_f(op, fs, a_eff, b);
    exp_q.push_back(e);
    model_last_lo = e[7:0];
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input int hold);
    logic [15:0] e;
    int          k;
    k = 0;
    while (!res_valid && k < 60) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, res_valid, 1);
    if (!res_valid) return;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, res_valid, 0);
      return;
    end
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check({tag, "_held_data"}, res_data, e[13:0]);
      tick();
    end
    check({tag, "_data"}, res_data, e[13:0]);
    check({tag, "_flag"}, res_flag, e[14]);
    check({tag, "_ovf"},  res_ovf,  e[15]);
    got_data = res_data; got_flag = res_flag; got_ovf = res_ovf;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_cleared"}, res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    cmd_valid = 1'b0; cmd_op = '0; cmd_fsel = '0; cmd_a = '0; cmd_b = '0;
    cmd_chain = 1'b0; res_ready = 1'b0; model_last_lo = '0;
    got_data = '0; got_flag = 1'b0; got_ovf = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_alu_ui", alu_ui, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Add with latency: valid must rise on the 4th edge after acceptance
    send(OP_ADD, FSEL_A_GT_B, 8'd200, 8'd100, 1'b0);
    repeat (3) tick();
    check("lat_early_valid", res_valid, 0);
    check("lat_busy", busy, 1);
    tick();
    check("lat_n4_valid", res_valid, 1);
    get_result("add", 0);
    check("add_lit_data", got_data, 14'h012C);
    check("add_lit_ovf", got_ovf, 1);
    check("add_lit_flag", got_flag, 1);

    send(OP_SUB, FSEL_A_EQ_B, 8'd5, 8'd7, 1'b0);
    get_result("sub", 0);
    check("sub_lit_data", got_data, 14'h3FFE);
    check("sub_lit_ovf", got_ovf, 1);
    check("sub_lit_flag", got_flag, 0);

    send(OP_MULT, FSEL_A_ZERO, 8'd15, 8'd17, 1'b0);
    get_result("mult", 0);
    check("mult_lit_data", got_data, 14'h00FF);
    check("mult_lit_ovf", got_ovf, 0);

    // Back-pressure: one in flight plus four queued
    send(OP_ADD,  FSEL_A_EVEN, 8'd1,   8'd2,   1'b0);
    send(OP_SUB,  FSEL_A_GT_B, 8'd90,  8'd30,  1'b0);
    send(OP_MULT, FSEL_A_EQ_B, 8'd12,  8'd12,  1'b0);
    send(OP_ADD,  FSEL_A_ZERO, 8'd0,   8'd255, 1'b0);
    send(OP_SUB,  FSEL_A_EVEN, 8'd17,  8'd200, 1'b0);
    check("full_level", fifo_level, 4);
    check("full_cmd_ready", cmd_ready, 0);
    get_result("bp0", 3);
    check("full_idle_level", fifo_level, 4);
    // Push offered on the popping edge while full: must be refused
    cmd_op = OP_MULT; cmd_fsel = FSEL_A_GT_B; cmd_a = 8'd3; cmd_b = 8'd3; cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    check("full_pop_ready", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0;
    check("full_pop_level", fifo_level, 3);
    get_result("bp1", 2);
    get_result("bp2", 1);
    get_result("bp3", 2);
    get_result("bp4", 0);
    repeat (8) tick();
    check("drain_busy", busy, 0);
    check("drain_res_valid", res_valid, 0);
    check("drain_level", fifo_level, 0);
    check("drain_alu_ctrl", alu_ctrl, 0);
    check("drain_alu_ui", alu_ui, 0);

    // Reset while a command is in EXEC with two more queued
    send(OP_ADD, FSEL_A_GT_B, 8'd10, 8'd20, 1'b0);
    send(OP_ADD, FSEL_A_GT_B, 8'd11, 8'd21, 1'b0);
    send(OP_ADD, FSEL_A_GT_B, 8'd12, 8'd22, 1'b0);
    tick();
    check("pre_rst_level", fifo_level, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    model_last_lo = '0;
    tick();
    check("mid_rst_hold_valid", res_valid, 0);
    rst_n = 1'b1;
    tick(); tick();
    check("after_rst_busy", busy, 0);
    send(OP_SUB, FSEL_A_EVEN, 8'd100, 8'd1, 1'b0);
    get_result("after_rst", 0);
    check("after_rst_lit", got_data, 14'd99);

    // Chaining
    send(OP_ADD, FSEL_A_EVEN, 8'd3, 8'd4, 1'b0);
    get_result("chain_base", 0);
    check("chain_base_lit", got_data, 14'd7);
    send(OP_ADD, FSEL_A_GT_B, 8'd99, 8'd10, 1'b1);
    get_result("chain", 0);
`ifdef ALUSEQ_CHAIN_EN
    check("chain_lit", got_data, 14'h0011);
`else
    check("chain_lit", got_data, 14'd109);
`endif

    // Random traffic with random consumer delays
    for (int i = 0; i < 24; i++) begin
      if (exp_q.size() > 0 && (!cmd_ready || $urandom_range(0, 2) == 0))
        get_result("rand", int'($urandom_range(0, 2)));
      case ($urandom_range(0, 2))
        0:       rop = OP_ADD;
        1:       rop = OP_SUB;
        default: rop = OP_MULT;
      endcase
      send(rop, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)));
    end
    for (int j = 0; j < 8 && exp_q.size() > 0; j++) get_result("rand_drain", 0);
    repeat (8) tick();
    check("end_busy", busy, 0);
    check("end_res_valid", res_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
